mult_seq: RTL and testbench

//  Iterative shift-add 32x32 multiplier for the CPU54 MULT/MULTU path. Companion to the

---
 rtl/cpu54_pkg.sv | 14 +
 rtl/mult_seq_twos_abs.sv | 19 +
 rtl/mult_seq.sv | 150 +++++++++++++++
 tb/tb_mult_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu54_pkg.sv
// cpu54_pkg: definitions shared by the CPU54 EX-stage arithmetic units.
//  - CPU_WIDTH   : default datapath width
//  - mul_state_e : state encodings of the sequential multiplier (2 bits)
package cpu54_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_SIGN = 2'd2
    } mul_state_e;

endpackage : cpu54_pkg

// File: rtl/mult_seq_twos_abs.sv
// twos_abs: conditional two's-complement negate.
// Used for the operand magnitudes (neg_i = sign bit) and for the final sign fix
// of the product (neg_i = result sign).
//  Ports:
//   val_i  in  W   value to (optionally) negate
//   neg_i  in  1   1 = return -val_i, 0 = pass val_i through
//   res_o  out W   result, modulo 2^W
module twos_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    // Negation wraps modulo 2^W, so |most-negative| reads back correctly as unsigned.
    assign res_o = neg_i ? ({W{1'b0}} - val_i) : val_i;

endmodule : twos_abs

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add WIDTH x WIDTH multiplier for MULT / MULTU.
// One partial product per cycle on operand magnitudes, then a single sign-fix
// cycle, so latency is always WIDTH+1 cycles from the start edge to done.
// A start in any state (re)loads the operands and abandons the current work.
//  Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high
//   start      in   1      one-cycle request; samples a, b, is_signed
//   is_signed  in   1      1 = MULT (two's complement), 0 = MULTU
//   a, b       in   WIDTH  multiplicand, multiplier
//   hi, lo     out  WIDTH  upper / lower half of the product
//   busy       out  1      operation in flight
//   done       out  1      one-cycle pulse; hi/lo valid in that cycle
module mult_seq
    import cpu54_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     sum_s;

    twos_abs #(.W(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (is_signed & a[WIDTH-1]),
        .res_o (mag_a_s)
    );

    twos_abs #(.W(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (is_signed & b[WIDTH-1]),
        .res_o (mag_b_s)
    );

    // The unsigned magnitude product sits in {acc, mplier} once RUN completes.
    twos_abs #(.W(2*WIDTH)) u_sign_fix (
        .val_i ({acc_q, mplier_q}),
        .neg_i (neg_q),
        .res_o (prod_s)
    );

    // Next-state and datapath update; start takes priority over every state.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // The carry out of the add lands in acc's MSB after the shift.
        sum_s    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

        if (start) begin
            mcand_d  = mag_a_s;
            mplier_d = mag_b_s;
            neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_d    = {WIDTH{1'b0}};
            count_d  = {CNT_W{1'b0}};
            busy_d   = 1'b1;
            state_d  = MUL_RUN;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    busy_d = 1'b0;
                end
                MUL_RUN: begin
                    {acc_d, mplier_d} = {sum_s, mplier_q[WIDTH-1:1]};
                    if (count_q == CNT_LAST) begin
                        state_d = MUL_SIGN;
                    end else begin
                        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                MUL_SIGN: begin
                    {hi_d, lo_d} = prod_s;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = MUL_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = MUL_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything including hi/lo.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed corner cases plus randomized MULT/MULTU operations
// checked against a plain-arithmetic 64-bit product model.
module tb_mult_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_pass;
    logic [63:0] prev_prod;

    mult_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint      sx, sy;
        logic [63:0] ux, uy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
        end else begin
            ux = {32'd0, x};
            uy = {32'd0, y};
            return ux * uy;
        end
    endfunction

    // Start one operation, then follow it to done checking latency, busy,
    // hold of the previous result, the product, and the single-cycle done.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic ts);
        logic [63:0] exp;
        int          e;
        logic        busy_ok;
        logic        hold_ok;
        exp = ref_mul(ta, tb, ts);
        @(negedge clock);
        a = ta; b = tb; is_signed = ts; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        e = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!done && e < 100) begin
            if (!busy) busy_ok = 1'b0;
            if ({hi, lo} !== prev_prod) hold_ok = 1'b0;
            @(negedge clock);
            e++;
        end
        check({tag, "_latency"}, 64'(e), 64'd33);
        check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_prod"}, {hi, lo}, exp);
        @(negedge clock);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        prev_prod = exp;
    endtask

    initial begin
        int          e;
        int          n_done;
        logic        hold_ok;
        logic [31:0] ra, rb;
        logic        rs;

        n_checks = 0; n_pass = 0; prev_prod = 64'd0;
        start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_out", {hi, lo}, 64'd0);
        check("reset_ctl", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;

        do_op("multu_7x6", 32'd7, 32'd6, 1'b0);
        do_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
        do_op("mult_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("mult_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        do_op("mult_minx1", 32'h8000_0000, 32'd1, 1'b1);
        do_op("mult_zero", 32'd0, 32'hDEAD_BEEF, 1'b1);

        // Restart: 3*4 at edge 0, 5*5 at edge 10; only one done, at edge 43.
        @(negedge clock);
        a = 32'd3; b = 32'd4; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        e = 0; n_done = 0; hold_ok = 1'b1;
        while (e < 9) begin
            @(negedge clock);
            e++;
            if (done) n_done++;
            if ({hi, lo} !== prev_prod) hold_ok = 1'b0;
        end
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clock);
        e++;
        start = 1'b0;
        while (!done && e < 120) begin
            if ({hi, lo} !== prev_prod) hold_ok = 1'b0;
            @(negedge clock);
            e++;
        end
        check("restart_latency", 64'(e), 64'd43);
        check("restart_no_early_done", 64'(n_done), 64'd0);
        check("restart_hold", {63'd0, hold_ok}, 64'd1);
        check("restart_prod", {hi, lo}, 64'd25);
        prev_prod = 64'd25;

        // Reset in the middle of RUN, just before edge 15.
        @(negedge clock);
        a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", {hi, lo}, 64'd0);
        check("async_reset_ctl", {62'd0, busy, done}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        check("reset_abort_quiet", 64'(n_done), 64'd0);
        prev_prod = 64'd0;
        do_op("after_reset_2x2", 32'd2, 32'd2, 1'b0);

        // Randomized operands, biased toward sign-boundary values.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 32'h7FFF_FFFF;
                1:       rb = 32'h0000_0001;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            do_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mult_seq
